// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch resolution slice: opcode and word types,
// resolver FSM state, prediction record payload and block defaults.
package lc3b_types;

  localparam int unsigned WORD_W               = 16;
  localparam int unsigned HIST_W               = 8;
  localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDW  = 4'b0110,
    OP_STW  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  // One in-flight prediction, captured at fetch and consumed at resolve.
  typedef struct packed {
    lc3b_word          pc;
    logic              prediction;
    lc3b_word          target;
    logic [HIST_W-1:0] history;
  } pred_rec_t;

  localparam pred_rec_t PRED_REC_DEFAULT = '0;

  // Opcodes that change control flow and therefore carry a prediction record.
  function automatic logic is_control(input lc3b_opcode op);
    return (op == OP_BR) || (op == OP_JMP) || (op == OP_JSR) || (op == OP_TRAP);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// Circular FIFO of prediction records.
// Ports: clk, rst_n; push/pop/clear controls; wdata in; head_c is the
// combinational head record; full/empty are registered occupancy flags.
// A push while full is accepted only when a pop happens in the same cycle.
module pred_fifo
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  pred_rec_t wdata,
  output pred_rec_t head_c,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pred_rec_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !clear;
  assign head_c  = mem[rd_ptr];

  // Next occupancy; clear wins over any push/pop.
  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        end
        if (do_pop) begin
          rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Record storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: pairs each resolving control instruction with the
// oldest outstanding prediction, detects mispredicts, redirects fetch,
// flushes younger work for FLUSH_CYCLES cycles and trains the predictor.
// Inputs : clk, rst_n, stall, fetch-side prediction (if_*), resolve (res_*).
// Outputs: redirect_valid/redirect_pc, flush, predictor update (upd_*),
//          br_count/mp_count statistics, sticky overflow. All registered.
module branch_resolve
  import lc3b_types::*;
#(
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_valid,
  input  lc3b_word          if_pc,
  input  logic              if_prediction,
  input  lc3b_word          if_pred_target,
  input  logic [HIST_W-1:0] if_history,
  input  logic              res_valid,
  input  lc3b_opcode        res_opcode,
  input  lc3b_word          res_pc,
  input  logic              res_taken,
  input  lc3b_word          res_target,
  output logic              redirect_valid,
  output lc3b_word          redirect_pc,
  output logic              flush,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic [7:0]        upd_pc,
  output logic [HIST_W-1:0] upd_history,
  output lc3b_word          upd_target,
  output logic [15:0]       br_count,
  output logic [15:0]       mp_count,
  output logic              overflow
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state;
  br_state_e       state_nxt;
  logic [FC_W-1:0] flush_cnt;
  logic [FC_W-1:0] flush_cnt_nxt;
  logic            flush_nxt;

  pred_rec_t       head_c;
  pred_rec_t       rec;
  pred_rec_t       push_rec;
  logic            fifo_full;
  logic            fifo_empty;
  logic            res_acc;
  logic            mispredict;
  logic            push_req;
  logic            drop;
  lc3b_word        redirect_addr;
  logic            unused_rec_pc;

  // A resolve counts only for control opcodes, outside flush, when not stalled.
  assign res_acc    = res_valid && is_control(res_opcode) && (state == ST_IDLE) && !stall;
  assign rec        = fifo_empty ? PRED_REC_DEFAULT : head_c;
  assign mispredict = res_acc &&
                      ((rec.prediction != res_taken) ||
                       (rec.prediction && res_taken && (rec.target != res_target)));

  // Predictions fetched alongside a mispredict are wrong-path and discarded.
  assign push_req = if_valid && !stall && (state == ST_IDLE) && !mispredict;
  assign drop     = push_req && fifo_full && !res_acc;

  assign push_rec      = '{pc: if_pc, prediction: if_prediction,
                           target: if_pred_target, history: if_history};
  assign redirect_addr = res_taken ? res_target : res_pc + 16'd2;

  // Stored PC travels with the record for visibility; resolution uses res_pc.
  assign unused_rec_pc = ^rec.pc;

  pred_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pred_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_req),
    .pop    (res_acc),
    .clear  (mispredict),
    .wdata  (push_rec),
    .head_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Flush sequencer next-state; stall freezes the countdown.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    flush_nxt     = flush;
    if (!stall) begin
      unique case (state)
        ST_IDLE: begin
          if (mispredict) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
            flush_nxt     = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state_nxt = ST_IDLE;
            flush_nxt = 1'b0;
          end else begin
            flush_cnt_nxt = flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          flush_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      flush_cnt      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_taken      <= 1'b0;
      upd_pc         <= '0;
      upd_history    <= '0;
      upd_target     <= '0;
      br_count       <= '0;
      mp_count       <= '0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_nxt;
      flush_cnt      <= flush_cnt_nxt;
      flush          <= flush_nxt;
      redirect_valid <= mispredict;
      upd_valid      <= res_acc;
      if (mispredict) begin
        redirect_pc <= redirect_addr;
      end
      if (res_acc) begin
        upd_taken   <= res_taken;
        upd_pc      <= res_pc[7:0];
        upd_history <= rec.history;
        upd_target  <= res_target;
        if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      end
      if (mispredict && (mp_count != 16'hFFFF)) begin
        mp_count <= mp_count + 16'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
